// File: rtl/lut_access_arbiter.sv
// Shares one LUT reader among N_REQ requesters with round-robin grant and linear interpolation.
// Latency: req to done = 4 + L cycles (L = lut_read to lut_valid), done/err registered.
// Backpressure: requesters hold req until their done bit; one transaction in flight at a time.
module lut_access_arbiter #(
    parameter int N_REQ   = 4,
    parameter int FRAC_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [16*N_REQ-1:0]   req_x_i,
    output logic [N_REQ-1:0]      done_o,
    output logic                  err_o,
    output logic [15:0]           result_o,
    output logic                  busy_o,
    output logic                  lut_read_o,
    output logic [15:0]           lut_x_o,
    input  logic                  lut_valid_i,
    input  logic [15:0]           lut_base_i,
    input  logic [15:0]           lut_next_i,
    input  logic [FRAC_W-1:0]     lut_frac_i
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = 4;
    localparam int PROD_W = 17 + FRAC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_INTERP = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [15:0]         lut_x_q, lut_x_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         base_q, base_d;
    logic [15:0]         next_q, next_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [15:0]         result_q, result_d;
    logic                abort_q, abort_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                err_q, err_d;

    // Per-requester argument slices, unpacked for indexed selection.
    logic [15:0] slice_x [N_REQ];
    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slice_x[g] = req_x_i[16*g +: 16];
    end

    // Round-robin search: first set req bit at or after rr_ptr, wrapping.
    logic             found;
    logic [IDX_W-1:0] pick;
    always_comb begin : p_arb
        int               idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(rr_ptr_q) + k) % N_REQ;
            cand = IDX_W'(idx);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Interpolation on the captured pair; floor shift keeps the result between base and next.
    logic signed [16:0]       diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_sh;
    logic [15:0]              interp;
    always_comb begin
        diff    = $signed({next_q[15], next_q}) - $signed({base_q[15], base_q});
        prod    = PROD_W'(diff) * PROD_W'($signed({1'b0, frac_q}));
        prod_sh = prod >>> FRAC_W;
        interp  = base_q + prod_sh[15:0];
    end

    // Next-state and datapath updates for the transaction sequencer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        lut_x_d  = lut_x_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        next_d   = next_q;
        frac_d   = frac_q;
        result_d = result_q;
        abort_d  = abort_q;
        done_d   = '0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d   = pick;
                    lut_x_d = slice_x[pick];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lut_valid_i) begin
                    base_d  = lut_base_i;
                    next_d  = lut_next_i;
                    frac_d  = lut_frac_i;
                    state_d = S_INTERP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    abort_d  = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INTERP: begin
                result_d = interp;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done_d   = N_REQ'(1) << gnt_q;
                err_d    = abort_q;
                rr_ptr_d = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction without a done.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            lut_x_q  <= '0;
            cnt_q    <= '0;
            base_q   <= '0;
            next_q   <= '0;
            frac_q   <= '0;
            result_q <= '0;
            abort_q  <= 1'b0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            lut_x_q  <= lut_x_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            next_q   <= next_d;
            frac_q   <= frac_d;
            result_q <= result_d;
            abort_q  <= abort_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign done_o     = done_q;
    assign err_o      = err_q;
    assign result_o   = result_q;
    assign busy_o     = (state_q != S_IDLE);
    assign lut_read_o = (state_q == S_ISSUE);
    assign lut_x_o    = lut_x_q;

endmodule

// File: tb/tb_lut_access_arbiter.sv
// Bench for lut_access_arbiter: LUT model with 5-cycle read latency and a done scoreboard.
// Latency: expected transactions pushed at request time, popped when done pulses.
// Backpressure: requesters hold req until done (optionally dropped early by the test).
module tb_lut_access_arbiter;

    localparam int N_REQ  = 4;
    localparam int FRAC_W = 4;

    logic                clk;
    logic                reset_n;
    logic [N_REQ-1:0]    req;
    logic [16*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]    done;
    logic                err;
    logic [15:0]         result;
    logic                busy;
    logic                lut_read;
    logic [15:0]         lut_x;
    logic                lut_valid;
    logic [15:0]         lut_base;
    logic [15:0]         lut_next;
    logic [FRAC_W-1:0]   lut_frac;

    lut_access_arbiter #(.N_REQ(N_REQ), .FRAC_W(FRAC_W), .TIMEOUT(15)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .req_i       (req),
        .req_x_i     (req_x),
        .done_o      (done),
        .err_o       (err),
        .result_o    (result),
        .busy_o      (busy),
        .lut_read_o  (lut_read),
        .lut_x_o     (lut_x),
        .lut_valid_i (lut_valid),
        .lut_base_i  (lut_base),
        .lut_next_i  (lut_next),
        .lut_frac_i  (lut_frac)
    );

    typedef struct {
        int          idx;
        logic [15:0] x;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          reads = 0;
    int          last_done_cyc = 0;
    logic [15:0] read_x = '0;

    // LUT model controls
    logic [15:0]       cfg_base = '0;
    logic [15:0]       cfg_next = '0;
    logic [3:0]        cfg_frac = '0;
    bit                from_x   = 0;
    bit                spur     = 0;
    int                skip     = 0;
    bit                auto_drop = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_interp(input logic [15:0] b, input logic [15:0] n,
                                               input logic [3:0] f);
        int bi, ni, p, q;
        bi = int'($signed(b));
        ni = int'($signed(n));
        p  = (ni - bi) * int'(f);
        q  = p / 16;
        if (p < 0 && (p % 16) != 0) q = q - 1;
        return 16'(bi + q);
    endfunction

    function automatic logic [15:0] xb(input logic [15:0] x);
        return x;
    endfunction
    function automatic logic [15:0] xn(input logic [15:0] x);
        return x ^ 16'h5A5A;
    endfunction
    function automatic logic [3:0] xf(input logic [15:0] x);
        return x[3:0] ^ 4'h9;
    endfunction

    function automatic logic [15:0] slice(input int i);
        return req_x[16*i +: 16];
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LUT model: answers a read 5 cycles later, or skips it, or emits a spurious pulse.
    initial begin
        int pend;
        pend = 0;
        lut_valid = 1'b0;
        lut_base  = '0;
        lut_next  = '0;
        lut_frac  = '0;
        forever begin
            @(posedge clk);
            #1;
            lut_valid = 1'b0;
            if (!reset_n) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    lut_valid = 1'b1;
                    lut_base  = from_x ? xb(read_x) : cfg_base;
                    lut_next  = from_x ? xn(read_x) : cfg_next;
                    lut_frac  = from_x ? xf(read_x) : cfg_frac;
                    chk("lut_x_hold", lut_x, read_x);
                end
            end else if (spur) begin
                spur      = 0;
                lut_valid = 1'b1;
                lut_base  = 16'h1234;
                lut_next  = 16'h4321;
                lut_frac  = 4'h7;
            end
            if (reset_n && lut_read) begin
                reads++;
                read_x = lut_x;
                if (skip > 0) skip--;
                else pend = 5;
            end
        end
    end

    // Done monitor: pops the scoreboard and compares each completion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done != '0) begin
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("done_onehot", 32'(done), 32'(1) << e.idx);
                    chk("result", 32'(result), 32'(e.res));
                    chk("err", 32'(err), 32'(e.err));
                    chk("granted_x", 32'(read_x), 32'(e.x));
                end
                if (auto_drop) req = req & ~done;
            end
        end
    end

    task automatic push_exp(input int idx, input logic [15:0] res, input logic e);
        exp_t s;
        s.idx = idx;
        s.x   = slice(idx);
        s.res = res;
        s.err = e;
        sb.push_back(s);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sb.size() != 0 || busy); i++) tick(1);
        chk("drain_sb_empty", 32'(sb.size()), 32'h0);
    endtask

    task automatic wait_read(input int budget);
        int r0;
        r0 = reads;
        for (int i = 0; i < budget && reads == r0; i++) tick(1);
        chk("read_seen", 32'(reads != r0), 32'h1);
    endtask

    task automatic do_reset();
        #3;
        reset_n = 1'b0;
        req     = '0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int r0, c0;
        logic [15:0] prev;
        reset_n = 1'b0;
        req     = '0;
        req_x   = {16'hC004, 16'h8003, 16'h4002, 16'h0001};
        #1;
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_lut_read", 32'(lut_read), 32'h0);
        chk("rst_lut_x", 32'(lut_x), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // 1: single requester, latency 9
        cfg_base = 16'h1000; cfg_next = 16'h2000; cfg_frac = 4'd8;
        r0 = reads;
        push_exp(0, 16'h1800, 1'b0);
        req = 4'b0001;
        c0 = cyc;
        drain(60);
        chk("t1_reads", 32'(reads - r0), 32'h1);
        chk("t1_latency", 32'(last_done_cyc - c0), 32'd9);

        // 2: interpolation floor and zero fraction
        cfg_base = 16'h7FFF; cfg_next = 16'h7FF0; cfg_frac = 4'd15;
        push_exp(0, 16'h7FF0, 1'b0);
        req = 4'b0001;
        drain(60);
        cfg_base = 16'h8000; cfg_next = 16'h8010; cfg_frac = 4'd0;
        push_exp(0, 16'h8000, 1'b0);
        req = 4'b0001;
        drain(60);

        // 3: all requesters continuously high, round-robin order
        do_reset();
        from_x = 1; auto_drop = 0;
        r0 = reads;
        for (int t = 0; t < 8; t++)
            push_exp(t % 4, exp_interp(xb(slice(t % 4)), xn(slice(t % 4)), xf(slice(t % 4))), 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        req = '0;
        drain(60);
        chk("t3_reads", 32'(reads - r0), 32'd8);
        auto_drop = 1;

        // 4: LUT never answers the first read; next requester then served
        do_reset();
        skip = 1;
        push_exp(0, 16'h0000, 1'b1);
        push_exp(1, exp_interp(xb(slice(1)), xn(slice(1)), xf(slice(1))), 1'b0);
        req = 4'b0011;
        drain(120);

        // 5: asynchronous reset while waiting on the LUT
        from_x = 0;
        cfg_base = 16'hF000; cfg_next = 16'h0FF0; cfg_frac = 4'd5;
        push_exp(0, exp_interp(16'hF000, 16'h0FF0, 4'd5), 1'b0);
        req = 4'b0001;
        wait_read(20);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        req = '0;
        sb.delete();
        #1;
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_err", 32'(err), 32'h0);
        chk("t5_result", 32'(result), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_lut_read", 32'(lut_read), 32'h0);
        chk("t5_lut_x", 32'(lut_x), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(8);
        push_exp(0, exp_interp(16'hF000, 16'h0FF0, 4'd5), 1'b0);
        req = 4'b0001;
        drain(60);

        // 6: spurious lut_valid while idle, then req[2] dropped mid-wait
        prev = result;
        spur = 1;
        tick(4);
        chk("t6_idle_busy", 32'(busy), 32'h0);
        chk("t6_idle_result", 32'(result), 32'(prev));
        cfg_base = 16'h0100; cfg_next = 16'hFF00; cfg_frac = 4'd3;
        push_exp(2, exp_interp(16'h0100, 16'hFF00, 4'd3), 1'b0);
        req = 4'b0100;
        wait_read(20);
        tick(2);
        req = '0;
        drain(60);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
